// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short, double and long press pulses,
// plus a held-long level for hold behaviours in the top-level FSM.
module button_event_classifier #(
    parameter int LONG_CYCLES = 250000000,
    parameter int GAP_CYCLES  = 15000000,
    parameter int CNT_W       = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic long_active,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        GAP       = 3'd2,
        PRESS2    = 3'd3,
        HELD_LONG = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             short_n, double_n, long_n, long_active_n, busy_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            long_active  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            short_press  <= short_n;
            double_press <= double_n;
            long_press   <= long_n;
            long_active  <= long_active_n;
            busy         <= busy_n;
        end
    end

    // cnt holds the number of samples already seen in the current phase,
    // so the terminal compare fires on the last qualifying sample.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        short_n       = 1'b0;
        double_n      = 1'b0;
        long_n        = 1'b0;
        long_active_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (btn_level) begin
                    state_n = PRESS1;
                    cnt_n   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (btn_level) begin
                    if (cnt == LONG_LAST) begin
                        state_n       = HELD_LONG;
                        cnt_n         = '0;
                        long_n        = 1'b1;
                        long_active_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end else begin
                    state_n = GAP;
                    cnt_n   = CNT_ONE;
                end
            end
            GAP: begin
                if (btn_level) begin
                    state_n  = PRESS2;
                    cnt_n    = '0;
                    double_n = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    short_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            PRESS2: begin
                cnt_n = '0;
                if (!btn_level) state_n = IDLE;
            end
            HELD_LONG: begin
                cnt_n = '0;
                if (btn_level) long_active_n = 1'b1;
                else           state_n       = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
